// File: rtl/barrel_rotator_pipelined.sv
// Pipelined N-bit rotator: one registered stage per amount bit, valid/ready on both sides.
// Optional macro BARREL_ROTATOR_LOGICAL_MODE_EN adds in_logical (zero-fill shift instead of rotate).
module barrel_rotator_pipelined #(
    parameter  int unsigned N  = 8,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amount,
    input  logic          in_dir,
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
    input  logic          in_logical,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    localparam int unsigned L = AW;

    logic [L-1:0]  valid_q;
    logic [N-1:0]  data_q [L];
    logic [AW-1:0] amt_q  [L];
    logic          dir_q  [L];
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
    logic          lgc_q  [L];
`endif

    logic [L-1:0]   stg_valid;
    logic [N-1:0]   stg_data [L];
    logic [AW-1:0]  stg_amt  [L];
    logic           stg_dir  [L];
    logic           stg_lgc  [L];
    logic [N-1:0]   stg_next [L];
    logic [L-1:0]   adv;
    logic           full;
    logic [2*N-1:0] wide;

    // Stage k input: the primary inputs for stage 0, otherwise the previous stage register.
    always_comb begin
        stg_valid[0] = in_valid;
        stg_data[0]  = in_data;
        stg_amt[0]   = in_amount;
        stg_dir[0]   = in_dir;
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        stg_lgc[0]   = in_logical;
`else
        stg_lgc[0]   = 1'b0;
`endif
        for (int unsigned k = 1; k < L; k++) begin
            stg_valid[k] = valid_q[k-1];
            stg_data[k]  = data_q[k-1];
            stg_amt[k]   = amt_q[k-1];
            stg_dir[k]   = dir_q[k-1];
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
            stg_lgc[k]   = lgc_q[k-1];
`else
            stg_lgc[k]   = 1'b0;
`endif
        end
    end

    // Stage k moves by 2^k, which is always < N, so the doubled-word trick never wraps twice.
    always_comb begin
        wide = '0;
        for (int unsigned k = 0; k < L; k++) begin
            stg_next[k] = stg_data[k];
            if (stg_amt[k][k]) begin
                if (stg_lgc[k]) begin
                    stg_next[k] = stg_dir[k] ? (stg_data[k] >> (1 << k)) : (stg_data[k] << (1 << k));
                end else if (stg_dir[k]) begin
                    wide        = {stg_data[k], stg_data[k]} >> (1 << k);
                    stg_next[k] = wide[N-1:0];
                end else begin
                    wide        = {stg_data[k], stg_data[k]} << (1 << k);
                    stg_next[k] = wide[2*N-1:N];
                end
            end
        end
    end

    // Advance chain unrolled: stage k moves unless it and every stage after it is full and stalled.
    always_comb begin
        full = 1'b1;
        for (int unsigned k = 0; k < L; k++) begin
            full = 1'b1;
            for (int unsigned j = k; j < L; j++) begin
                full = full & valid_q[j];
            end
            adv[k] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < L; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                dir_q[k]  <= 1'b0;
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
                lgc_q[k]  <= 1'b0;
`endif
            end
        end else begin
            for (int unsigned k = 0; k < L; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= stg_valid[k];
                    if (stg_valid[k]) begin
                        data_q[k] <= stg_next[k];
                        amt_q[k]  <= stg_amt[k];
                        dir_q[k]  <= stg_dir[k];
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
                        lgc_q[k]  <= stg_lgc[k];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];

endmodule

// File: tb/tb_barrel_rotator_pipelined.sv
// Bench for barrel_rotator_pipelined: four instances (N = 8, 12, 5, 16) driven through one generic harness.
module tb_barrel_rotator_pipelined;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  iv, idir, ilg, ordy;
    logic [15:0] id [4];
    logic [3:0]  ia [4];
    logic [15:0] od [4];
    logic [3:0]  ov, ir;

    logic [7:0]  od8;
    logic [11:0] od12;
    logic [4:0]  od5;
    logic [15:0] od16;
    logic r8, r12, r5, r16, v8, v12, v5, v16;

    assign od[0] = {8'h00, od8};
    assign od[1] = {4'h0, od12};
    assign od[2] = {11'h000, od5};
    assign od[3] = od16;
    assign ov = {v16, v5, v12, v8};
    assign ir = {r16, r5, r12, r8};

    barrel_rotator_pipelined #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(r8), .in_data(id[0][7:0]),
        .in_amount(ia[0][2:0]), .in_dir(idir[0]),
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        .in_logical(ilg[0]),
`endif
        .out_valid(v8), .out_ready(ordy[0]), .out_data(od8));

    barrel_rotator_pipelined #(.N(12)) u12 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(r12), .in_data(id[1][11:0]),
        .in_amount(ia[1][3:0]), .in_dir(idir[1]),
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        .in_logical(ilg[1]),
`endif
        .out_valid(v12), .out_ready(ordy[1]), .out_data(od12));

    barrel_rotator_pipelined #(.N(5)) u5 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(r5), .in_data(id[2][4:0]),
        .in_amount(ia[2][2:0]), .in_dir(idir[2]),
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        .in_logical(ilg[2]),
`endif
        .out_valid(v5), .out_ready(ordy[2]), .out_data(od5));

    barrel_rotator_pipelined #(.N(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(r16), .in_data(id[3]),
        .in_amount(ia[3]), .in_dir(idir[3]),
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        .in_logical(ilg[3]),
`endif
        .out_valid(v16), .out_ready(ordy[3]), .out_data(od16));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          u;
        logic [15:0] d;
        logic [3:0]  a;
        logic        dir;
        logic        lg;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic int unsigned n_of(input int u);
        case (u)
            0: return 8;
            1: return 12;
            2: return 5;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned lat_of(input int u);
        case (u)
            0, 2: return 3;
            default: return 4;
        endcase
    endfunction

    // Bit-position reference: rotate by (a mod n) or zero-fill shift by a.
    function automatic logic [15:0] ref_rot(input logic [15:0] d, input int unsigned a,
                                            input logic dir, input logic lg, input int unsigned n);
        logic [15:0] r;
        int unsigned s;
        r = '0;
        if (lg) begin
            if (a >= n) return '0;
            for (int unsigned i = 0; i < n; i++) begin
                if (!dir && i >= a) r[i] = d[i-a];
                if (dir && i + a < n) r[i] = d[i+a];
            end
        end else begin
            s = a % n;
            for (int unsigned i = 0; i < n; i++) begin
                if (!dir) r[(i+s)%n] = d[i];
                else      r[i] = d[(i+s)%n];
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input int u, input logic [15:0] d, input logic [3:0] a,
                                input logic dir, input logic lg, input logic [15:0] exp, input string name);
        vec_t v;
        v.u = u; v.d = d; v.a = a; v.dir = dir; v.lg = lg; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic [15:0] d, input logic [3:0] a,
                         input logic dr, input logic lg);
        iv[u] = 1'b1; id[u] = d; ia[u] = a; idir[u] = dr; ilg[u] = lg;
    endtask

    task automatic single(input vec_t v);
        int n;
        n = 0;
        ordy[v.u] = 1'b1;
        drive(v.u, v.d, v.a, v.dir, v.lg);
        #1;
        while (!ir[v.u] && n < 20) begin tick(); n++; end
        @(posedge clk);
        #1;
        iv[v.u] = 1'b0;
        n = 1;
        while (!ov[v.u] && n < 20) begin tick(); n++; end
        check({v.name, " latency"}, 16'(n), 16'(lat_of(v.u)));
        check({v.name, " data"}, od[v.u], v.exp);
        tick();
        check({v.name, " one-cycle valid"}, {15'h0, ov[v.u]}, 16'h0);
    endtask

    task automatic run_stream(input int u, input int nitems);
        logic [15:0] q[$];
        logic [15:0] mask;
        int sent, got, cyc, seen;
        logic acc;
        sent = 0; got = 0; cyc = 0;
        mask = 16'((32'h1 << n_of(u)) - 1);
        iv[u] = 1'b0;
        while (got < nitems && cyc < nitems * 12) begin
            if (!iv[u] && sent < nitems && $urandom_range(0, 3) != 0) begin
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
                drive(u, 16'($urandom) & mask, 4'($urandom_range(0, (1 << lat_of(u)) - 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
                drive(u, 16'($urandom) & mask, 4'($urandom_range(0, (1 << lat_of(u)) - 1)),
                      1'($urandom_range(0, 1)), 1'b0);
`endif
            end
            ordy[u] = ($urandom_range(0, 3) != 0);
            #1;
            if (ov[u] && ordy[u]) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream%0d extra output: got %h, expected none", u, od[u]);
                end else begin
                    check($sformatf("stream%0d item %0d", u, got), od[u], q.pop_front());
                end
                got++;
            end
            acc = iv[u] & ir[u];
            if (acc) begin
                q.push_back(ref_rot(id[u], ia[u], idir[u], ilg[u], n_of(u)));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) iv[u] = 1'b0;
            cyc++;
        end
        check($sformatf("stream%0d count", u), 16'(got), 16'(nitems));
        ordy[u] = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ov[u]) seen++;
            tick();
        end
        check($sformatf("stream%0d no trailing output", u), 16'(seen), 16'h0);
        ordy[u] = 1'b0;
    endtask

    logic [15:0] sd [5];
    logic [3:0]  sa [5];
    logic        sdir [5];

    initial begin
        int k, got, first, last, seen;
        logic [15:0] hold;
        iv = '0; idir = '0; ilg = '0; ordy = '0;
        for (int u = 0; u < 4; u++) begin id[u] = '0; ia[u] = '0; end

        vecs.push_back(mk(0, 16'h00C5, 3, 1, 0, 16'h00B8, "n8 C5 r3"));
        vecs.push_back(mk(0, 16'h00C5, 3, 0, 0, 16'h002E, "n8 C5 l3"));
        vecs.push_back(mk(0, 16'h00C5, 0, 0, 0, 16'h00C5, "n8 C5 l0"));
        vecs.push_back(mk(0, 16'h00C5, 0, 1, 0, 16'h00C5, "n8 C5 r0"));
        vecs.push_back(mk(0, 16'h0001, 7, 0, 0, 16'h0080, "n8 01 l7"));
        vecs.push_back(mk(0, 16'h0001, 1, 1, 0, 16'h0080, "n8 01 r1"));
        vecs.push_back(mk(0, 16'h00A5, 4, 0, 0, 16'h005A, "n8 A5 l4"));
        vecs.push_back(mk(1, 16'h0801, 13, 0, 0, 16'h0003, "n12 801 l13"));
        vecs.push_back(mk(1, 16'h0801, 13, 1, 0, 16'h0C00, "n12 801 r13"));
        vecs.push_back(mk(1, 16'h0801, 12, 0, 0, 16'h0801, "n12 801 l12"));
        vecs.push_back(mk(1, 16'h0001, 15, 0, 0, 16'h0008, "n12 001 l15"));
        vecs.push_back(mk(2, 16'h0001, 6, 0, 0, 16'h0002, "n5 01 l6"));
        vecs.push_back(mk(2, 16'h0001, 7, 1, 0, 16'h0008, "n5 01 r7"));
        vecs.push_back(mk(2, 16'h0013, 0, 1, 0, 16'h0013, "n5 13 r0"));
        vecs.push_back(mk(3, 16'h0001, 15, 0, 0, 16'h8000, "n16 0001 l15"));
        vecs.push_back(mk(3, 16'h1234, 4, 0, 0, 16'h2341, "n16 1234 l4"));
        vecs.push_back(mk(3, 16'h1234, 8, 1, 0, 16'h3412, "n16 1234 r8"));
`ifdef BARREL_ROTATOR_LOGICAL_MODE_EN
        vecs.push_back(mk(0, 16'h00C5, 3, 1, 1, 16'h0018, "n8 logical r3"));
        vecs.push_back(mk(0, 16'h00C5, 7, 0, 1, 16'h0080, "n8 logical l7"));
        vecs.push_back(mk(2, 16'h001F, 5, 0, 1, 16'h0000, "n5 logical l5"));
`endif

        tick(); tick();
        for (int u = 0; u < 4; u++) begin
            check($sformatf("reset out_valid u%0d", u), {15'h0, ov[u]}, 16'h0);
            check($sformatf("reset out_data u%0d", u), od[u], 16'h0);
            check($sformatf("reset in_ready u%0d", u), {15'h0, ir[u]}, 16'h1);
        end
        rst = 1'b0;
        tick();

        foreach (vecs[i]) single(vecs[i]);

        // Stall: five back-to-back items against a blocked consumer.
        sd[0] = 16'h00C5; sa[0] = 3; sdir[0] = 1;
        sd[1] = 16'h003C; sa[1] = 1; sdir[1] = 0;
        sd[2] = 16'h0081; sa[2] = 5; sdir[2] = 1;
        sd[3] = 16'h00F0; sa[3] = 2; sdir[3] = 0;
        sd[4] = 16'h000F; sa[4] = 6; sdir[4] = 1;
        ordy[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 5) drive(0, sd[k], sa[k], sdir[k], 1'b0);
            #1;
            if (iv[0] && ir[0]) k++;
            tick();
        end
        check("stall accepted", 16'(k), 16'd3);
        check("stall in_ready low", {15'h0, ir[0]}, 16'h0);
        check("stall out_valid", {15'h0, ov[0]}, 16'h1);
        hold = od[0];
        check("stall head", hold, ref_rot(sd[0], sa[0], sdir[0], 1'b0, 8));
        tick(); tick(); tick();
        check("stall data stable", od[0], hold);
        check("stall valid stable", {15'h0, ov[0]}, 16'h1);
        ordy[0] = 1'b1;
        #1;
        check("full pipe no bubble", {15'h0, ir[0]}, 16'h1);
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (k < 5) drive(0, sd[k], sa[k], sdir[k], 1'b0);
            else iv[0] = 1'b0;
            #1;
            if (ov[0]) begin
                check($sformatf("stall order %0d", got), od[0],
                      ref_rot(sd[got], sa[got], sdir[got], 1'b0, 8));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (iv[0] && ir[0]) k++;
            tick();
        end
        iv[0] = 1'b0;
        check("stall drained", 16'(got), 16'd5);
        check("stall back-to-back", 16'(last - first), 16'd4);

        // Asynchronous reset with three items in flight.
        ordy[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            drive(0, 16'h0055 + 16'(c), 3'd1, 1'b0, 1'b0);
            #1;
            if (ir[0]) k++;
            tick();
        end
        iv[0] = 1'b0;
        check("pre-reset out_valid", {15'h0, ov[0]}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", {15'h0, ov[0]}, 16'h0);
        check("async reset out_data", od[0], 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post-reset in_ready", {15'h0, ir[0]}, 16'h1);
        ordy[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (ov[0]) seen++;
            tick();
        end
        check("no stale after reset", 16'(seen), 16'h0);
        ordy[0] = 1'b0;

        run_stream(2, 350);
        run_stream(0, 350);
        run_stream(3, 350);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
